// File: rtl/tx_filt.sv
// 21-tap linear-phase SRRC transmit FIR (roll-off 0.25, 4 samples/symbol), 1s17 in and out.
// The symmetric taps are folded before multiplying, so the datapath needs 11 multipliers.
module tx_filt (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [17:0] x_in,
    output logic signed [17:0] y
);

    localparam int unsigned NumTaps = 21;
    localparam int unsigned NumFold = 10;

    localparam logic signed [17:0] Coef [11] = '{
        18'sd1404,  18'sd2023,  18'sd1142,  -18'sd1183, -18'sd3661, -18'sd4272,
        -18'sd1382, 18'sd5115,  18'sd13369, 18'sd20279, 18'sd22968
    };

    logic signed [17:0] x_q [NumTaps];
    logic signed [17:0] x_d [NumTaps];
    logic signed [17:0] y_q;
    logic signed [17:0] y_d;

    logic signed [18:0] pre  [NumFold];
    logic signed [36:0] prod [NumFold + 1];
    logic signed [39:0] acc;

    always_comb begin
        x_d[0] = x_in;
        for (int k = 1; k < NumTaps; k++) begin
            x_d[k] = x_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NumFold; k++) begin
            pre[k]  = 19'(x_q[k]) + 19'(x_q[NumTaps-1-k]);
            prod[k] = 37'(pre[k]) * 37'(Coef[k]);
        end
        prod[NumFold] = 37'(x_q[NumFold]) * 37'(Coef[NumFold]);

        acc = '0;
        for (int k = 0; k <= NumFold; k++) begin
            acc = acc + 40'(prod[k]);
        end
        // Coefficient magnitudes sum below 2^17, so the truncated result always fits 1s17.
        y_d = 18'(acc >>> 17);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NumTaps; k++) begin
                x_q[k] <= '0;
            end
            y_q <= '0;
        end else begin
            for (int k = 0; k < NumTaps; k++) begin
                x_q[k] <= x_d[k];
            end
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_tx_filt.sv
// Directed bench for tx_filt: reset, impulse, DC, worst-case extremes, symmetry and a 4-ASK stream.
module tb_tx_filt;

    logic               clk;
    logic               reset;
    logic signed [17:0] x_in;
    logic signed [17:0] y;

    int checks;
    int errors;

    int coef [21] = '{1404, 2023, 1142, -1183, -3661, -4272, -1382, 5115, 13369, 20279, 22968,
                      20279, 13369, 5115, -1382, -4272, -3661, -1183, 1142, 2023, 1404};

    tx_filt dut (
        .clk  (clk),
        .reset(reset),
        .x_in (x_in),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one sample, let it be captured, then settle past the edge.
    task automatic cyc(input logic signed [17:0] v);
        x_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 22; i++) cyc(18'sd0);
    endtask

    task automatic test_reset();
        checks++;
        if (y !== 18'sd0) begin
            errors++;
            $display("FAIL reset_initial: y=%0d expected 0", y);
        end
        #3 reset = 1'b1;
        for (int i = 0; i < 30; i++) cyc(18'($urandom));
        #3 reset = 1'b0;
        #1;
        checks++;
        if (y !== 18'sd0) begin
            errors++;
            $display("FAIL reset_async: y=%0d expected 0", y);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(18'($urandom));
            checks++;
            if (y !== 18'sd0) begin
                errors++;
                $display("FAIL reset_hold: cycle %0d y=%0d expected 0", i, y);
            end
        end
        x_in = 18'sd0;
        #3 reset = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cyc(18'sd0);
            checks++;
            if (y !== 18'sd0) begin
                errors++;
                $display("FAIL reset_release: cycle %0d y=%0d expected 0", i, y);
            end
        end
    endtask

    task automatic test_impulse();
        flush();
        cyc(-18'sd131072);
        for (int k = 0; k < 21; k++) begin
            cyc(18'sd0);
            checks++;
            if (y !== 18'(-coef[k])) begin
                errors++;
                $display("FAIL impulse_tap%0d: y=%0d expected %0d", k, y, -coef[k]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(18'sd0);
            checks++;
            if (y !== 18'sd0) begin
                errors++;
                $display("FAIL impulse_tail: y=%0d expected 0", y);
            end
        end
    endtask

    task automatic test_dc();
        flush();
        for (int i = 0; i < 22; i++) cyc(18'sd65536);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (y !== 18'sd44318) begin
                errors++;
                $display("FAIL dc_steady: cycle %0d y=%0d expected 44318", i, y);
            end
            cyc(18'sd65536);
        end
    endtask

    task automatic test_worst(input bit negative);
        logic signed [17:0] v;
        logic signed [17:0] expv;
        flush();
        for (int k = 20; k >= 0; k--) begin
            if ((coef[k] > 0) ^ negative) v = 18'sd131071;
            else                          v = -18'sd131072;
            cyc(v);
        end
        cyc(18'sd0);
        expv = negative ? -18'sd130628 : 18'sd130627;
        checks++;
        if (y !== expv) begin
            errors++;
            $display("FAIL worst_%s: y=%0d expected %0d", negative ? "neg" : "pos", y, expv);
        end
    endtask

    task automatic test_symmetry();
        flush();
        cyc(18'sd65536);
        cyc(18'sd0);
        checks++;
        if (y !== 18'sd702) begin
            errors++;
            $display("FAIL sym_first_tap0: y=%0d expected 702", y);
        end
        cyc(18'sd0);
        checks++;
        if (y !== 18'sd1011) begin
            errors++;
            $display("FAIL sym_trunc_pos: y=%0d expected 1011", y);
        end
        cyc(18'sd0);
        cyc(18'sd0);
        checks++;
        if (y !== -18'sd592) begin
            errors++;
            $display("FAIL sym_trunc_neg: y=%0d expected -592", y);
        end
        for (int i = 0; i < 15; i++) cyc(18'sd0);
        cyc(18'sd65536);
        cyc(18'sd0);
        checks++;
        if (y !== 18'sd1404) begin
            errors++;
            $display("FAIL sym_pair_overlap: y=%0d expected 1404", y);
        end
        for (int i = 0; i < 19; i++) cyc(18'sd0);
        cyc(18'sd0);
        checks++;
        if (y !== 18'sd702) begin
            errors++;
            $display("FAIL sym_second_tap20: y=%0d expected 702", y);
        end
        cyc(18'sd0);
        checks++;
        if (y !== 18'sd0) begin
            errors++;
            $display("FAIL sym_tail: y=%0d expected 0", y);
        end
    endtask

    task automatic test_ask_stream();
        int     sym [16] = '{98304, -32768, 32768, -98304, 98304, 98304, -98304, -32768,
                             32768, 32768, -98304, 98304, -32768, 32768, -98304, -98304};
        longint hist [21];
        longint acc;
        logic signed [17:0] v;
        logic signed [17:0] expv;
        flush();
        for (int k = 0; k < 21; k++) hist[k] = 0;
        for (int n = 0; n < 16 * 4 + 22; n++) begin
            if (n < 64 && (n % 4) == 0) v = 18'(sym[n / 4]);
            else                        v = 18'sd0;
            acc = 0;
            for (int k = 0; k < 21; k++) acc += hist[k] * longint'(coef[k]);
            expv = 18'(acc >>> 17);
            for (int k = 20; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'(v);
            cyc(v);
            checks++;
            if (y !== expv) begin
                errors++;
                $display("FAIL ask_stream: sample %0d y=%0d expected %0d", n, y, expv);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        x_in   = 18'sd0;
        #2;
        test_reset();
        test_impulse();
        test_dc();
        test_worst(1'b0);
        test_worst(1'b1);
        test_symmetry();
        test_ask_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
